// File: rtl/mmio_bigreg_stager_if.sv
`default_nettype none
// ============================================================================
// Module      : mmio_bigreg_stager_if
// Description : Bundle between mem_map decode / consuming RTL (master side)
//               and the big-register stager (slave side).
// Revision    : 1.0 - initial release
// ============================================================================
interface mmio_bigreg_stager_if #(
    parameter int WD_DATA_WIDTH = 16,
    parameter int BIG_WIDTH     = 256,
    parameter int DEPTH         = 4
);
    localparam int c_SAMPLES = BIG_WIDTH / WD_DATA_WIDTH;
    localparam int c_IDXW    = $clog2(c_SAMPLES + 1);
    localparam int c_CNTW    = $clog2(DEPTH + 1);

    logic                     ps_wr_en;
    logic [c_IDXW-1:0]        ps_wr_idx;
    logic [WD_DATA_WIDTH-1:0] ps_wr_data;
    logic [1:0]               ps_wr_resp;
    logic                     ps_wr_resp_vld;
    logic                     ps_rd_en;
    logic [c_IDXW-1:0]        ps_rd_idx;
    logic [WD_DATA_WIDTH-1:0] ps_rd_data;
    logic                     ps_rd_vld;
    logic [BIG_WIDTH-1:0]     rtl_data;
    logic                     rtl_valid;
    logic                     rtl_ready;
    logic [c_SAMPLES-1:0]     fresh_mask;
    logic [c_CNTW-1:0]        fifo_count;

    // PS decode plus the consuming RTL block
    modport master (
        output ps_wr_en, ps_wr_idx, ps_wr_data, ps_rd_en, ps_rd_idx, rtl_ready,
        input  ps_wr_resp, ps_wr_resp_vld, ps_rd_data, ps_rd_vld,
        input  rtl_data, rtl_valid, fresh_mask, fifo_count
    );

    // The stager itself
    modport slave (
        input  ps_wr_en, ps_wr_idx, ps_wr_data, ps_rd_en, ps_rd_idx, rtl_ready,
        output ps_wr_resp, ps_wr_resp_vld, ps_rd_data, ps_rd_vld,
        output rtl_data, rtl_valid, fresh_mask, fifo_count
    );
endinterface
`default_nettype wire

// File: rtl/mmio_bigreg_stager.sv
`default_nettype none
// ============================================================================
// Module      : mmio_bigreg_stager
// Description : Assembles WD_DATA_WIDTH chunks written by the PS into a
//               BIG_WIDTH staging register; a write to index SAMPLES commits
//               the staged value into a commit FIFO for the RTL consumer.
//               Optional macro BIGREG_PARTIAL_COMMIT_EN: commit does not
//               require every chunk to be freshly written.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_bigreg_stager #(
    parameter int WD_DATA_WIDTH = 16,
    parameter int BIG_WIDTH     = 256,
    parameter int DEPTH         = 4
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    mmio_bigreg_stager_if.slave bus
);
    localparam int c_SAMPLES = BIG_WIDTH / WD_DATA_WIDTH;
    localparam int c_IDXW    = $clog2(c_SAMPLES + 1);
    localparam int c_CNTW    = $clog2(DEPTH + 1);
    localparam int c_PTRW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;
    localparam logic [1:0] c_RESP_DECERR = 2'b11;

    // Out-of-range read pattern (16'hFFFE at the default width)
    localparam logic [WD_DATA_WIDTH-1:0] c_RD_BAD = {{(WD_DATA_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [c_IDXW-1:0]        c_VALID_IDX = c_IDXW'(c_SAMPLES);

    logic [BIG_WIDTH-1:0]     r_staging;
    logic [c_SAMPLES-1:0]     r_fresh;
    logic [BIG_WIDTH-1:0]     r_mem [DEPTH];
    logic [c_PTRW-1:0]        r_wptr;
    logic [c_PTRW-1:0]        r_rptr;
    logic [c_CNTW-1:0]        r_count;
    logic [1:0]               r_wr_resp;
    logic                     r_wr_resp_vld;
    logic [WD_DATA_WIDTH-1:0] r_rd_data;
    logic                     r_rd_vld;

    logic                     w_chunk_wr;
    logic                     w_valid_wr;
    logic                     w_complete;
    logic                     w_room;
    logic                     w_push;
    logic                     w_pop;
    logic [1:0]               w_wr_resp;
    logic [WD_DATA_WIDTH-1:0] w_rd_data;
    logic [WD_DATA_WIDTH-1:0] w_chunk [c_SAMPLES];

    function automatic logic [c_PTRW-1:0] f_ptr_inc(input logic [c_PTRW-1:0] p);
        return (p == c_PTRW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Chunk view of the staging register for the read mux
    for (genvar gi = 0; gi < c_SAMPLES; gi++) begin : g_chunk_view
        assign w_chunk[gi] = r_staging[gi*WD_DATA_WIDTH +: WD_DATA_WIDTH];
    end

    assign w_pop      = (r_count != '0) && bus.rtl_ready;
    assign w_chunk_wr = bus.ps_wr_en && (bus.ps_wr_idx < c_VALID_IDX);
    assign w_valid_wr = bus.ps_wr_en && (bus.ps_wr_idx == c_VALID_IDX);
`ifdef BIGREG_PARTIAL_COMMIT_EN
    assign w_complete = 1'b1;
`else
    assign w_complete = &r_fresh;
`endif
    // A same-cycle pop frees the slot a full FIFO needs
    assign w_room     = (r_count < c_CNTW'(DEPTH)) || w_pop;
    assign w_push     = w_valid_wr && w_complete && w_room;

    // Write response decode: chunk OKAY, commit OKAY/SLVERR, anything else DECERR
    always_comb begin
        w_wr_resp = c_RESP_DECERR;
        if (w_chunk_wr) begin
            w_wr_resp = c_RESP_OKAY;
        end else if (w_valid_wr) begin
            w_wr_resp = w_push ? c_RESP_OKAY : c_RESP_SLVERR;
        end
    end

    // Read mux: staging chunk, queued count, or the out-of-range pattern
    always_comb begin
        w_rd_data = c_RD_BAD;
        if (bus.ps_rd_idx == c_VALID_IDX) begin
            w_rd_data = WD_DATA_WIDTH'(r_count);
        end else begin
            for (int i = 0; i < c_SAMPLES; i++) begin
                if (bus.ps_rd_idx == c_IDXW'(i)) begin
                    w_rd_data = w_chunk[i];
                end
            end
        end
    end

    // Staging register and fresh mask; staging survives a commit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_staging <= '0;
            r_fresh   <= '0;
        end else if (w_chunk_wr) begin
            for (int i = 0; i < c_SAMPLES; i++) begin
                if (bus.ps_wr_idx == c_IDXW'(i)) begin
                    r_staging[i*WD_DATA_WIDTH +: WD_DATA_WIDTH] <= bus.ps_wr_data;
                    r_fresh[i]                                  <= 1'b1;
                end
            end
        end else if (w_push) begin
            r_fresh <= '0;
        end
    end

    // Registered write response and read data, zero when not strobed
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_resp     <= '0;
            r_wr_resp_vld <= 1'b0;
            r_rd_data     <= '0;
            r_rd_vld      <= 1'b0;
        end else begin
            r_wr_resp     <= bus.ps_wr_en ? w_wr_resp : 2'b00;
            r_wr_resp_vld <= bus.ps_wr_en;
            r_rd_data     <= bus.ps_rd_en ? w_rd_data : '0;
            r_rd_vld      <= bus.ps_rd_en;
        end
    end

    // Commit FIFO storage; contents are masked by rtl_valid so need no reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= r_staging;
        end
    end

    // Commit FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= f_ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= f_ptr_inc(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.rtl_valid      = (r_count != '0);
    assign bus.rtl_data       = bus.rtl_valid ? r_mem[r_rptr] : '0;
    assign bus.fresh_mask     = r_fresh;
    assign bus.fifo_count     = r_count;
    assign bus.ps_wr_resp     = r_wr_resp;
    assign bus.ps_wr_resp_vld = r_wr_resp_vld;
    assign bus.ps_rd_data     = r_rd_data;
    assign bus.ps_rd_vld      = r_rd_vld;
endmodule
`default_nettype wire

// File: tb/tb_mmio_bigreg_stager.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_bigreg_stager
// Description : Self-checking bench for mmio_bigreg_stager. A queue/array
//               model predicts every output each cycle; directed tests add
//               literal expectations. Honours BIGREG_PARTIAL_COMMIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_bigreg_stager;
    localparam int W    = 16;
    localparam int BIG  = 256;
    localparam int S    = BIG / W;
    localparam int D    = 4;
    localparam int IDXW = $clog2(S + 1);

    logic clk = 1'b0;
    logic rst_n;
    int   nvec = 0;
    int   nerr = 0;
    bit   chk_on = 1'b0;
    bit   rx_on  = 1'b0;
    bit   drv_done = 1'b0;
    int   rx_cnt = 0;

    mmio_bigreg_stager_if #(.WD_DATA_WIDTH(W), .BIG_WIDTH(BIG), .DEPTH(D)) bus ();

    mmio_bigreg_stager #(.WD_DATA_WIDTH(W), .BIG_WIDTH(BIG), .DEPTH(D)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // ---------------- model state ----------------
    logic [W-1:0]   m_stg [S];
    logic [S-1:0]   m_fresh = '0;
    logic [BIG-1:0] m_q [$];
    logic [1:0]     e_wr_resp = 2'b00;
    logic           e_wr_vld  = 1'b0;
    logic [W-1:0]   e_rd_data = '0;
    logic           e_rd_vld  = 1'b0;

    task automatic chk(input string name, input logic [BIG-1:0] act, input logic [BIG-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [BIG-1:0] pat(input int base, input int k);
        logic [BIG-1:0] v;
        for (int i = 0; i < S; i++) v[i*W +: W] = W'(base + k*S + i);
        return v;
    endfunction

    // Model: what the register map must do at each clock edge
    always @(posedge clk) begin : p_model
        bit pop, push, complete;
        logic [BIG-1:0] v;
        if (!rst_n) begin
            for (int i = 0; i < S; i++) m_stg[i] = '0;
            m_fresh = '0;
            m_q.delete();
            e_wr_resp = 2'b00; e_wr_vld = 1'b0; e_rd_data = '0; e_rd_vld = 1'b0;
        end else begin
            pop  = (m_q.size() != 0) && bus.rtl_ready;
            push = 1'b0;
            e_rd_vld  = bus.ps_rd_en;
            e_rd_data = '0;
            if (bus.ps_rd_en) begin
                if (bus.ps_rd_idx < S)       e_rd_data = m_stg[bus.ps_rd_idx];
                else if (bus.ps_rd_idx == S) e_rd_data = W'(m_q.size());
                else                         e_rd_data = 16'hFFFE;
            end
            e_wr_vld  = bus.ps_wr_en;
            e_wr_resp = 2'b00;
            for (int i = 0; i < S; i++) v[i*W +: W] = m_stg[i];
            if (bus.ps_wr_en) begin
                if (bus.ps_wr_idx < S) begin
                    m_stg[bus.ps_wr_idx]   = bus.ps_wr_data;
                    m_fresh[bus.ps_wr_idx] = 1'b1;
                end else if (bus.ps_wr_idx == S) begin
`ifdef BIGREG_PARTIAL_COMMIT_EN
                    complete = 1'b1;
`else
                    complete = (m_fresh == {S{1'b1}});
`endif
                    if (complete && (m_q.size() < D || pop)) begin
                        push = 1'b1;
                        m_fresh = '0;
                    end else begin
                        e_wr_resp = 2'b10;
                    end
                end else begin
                    e_wr_resp = 2'b11;
                end
            end
            if (pop)  void'(m_q.pop_front());
            if (push) m_q.push_back(v);
        end
    end

    // Compare every output against the model away from the active edge
    always @(negedge clk) begin
        if (chk_on) begin
            chk("wr_resp_vld", bus.ps_wr_resp_vld, e_wr_vld);
            chk("wr_resp",     bus.ps_wr_resp,     e_wr_resp);
            chk("rd_vld",      bus.ps_rd_vld,      e_rd_vld);
            chk("rd_data",     bus.ps_rd_data,     e_rd_data);
            chk("rtl_valid",   bus.rtl_valid,      m_q.size() != 0);
            chk("rtl_data",    bus.rtl_data,       (m_q.size() != 0) ? m_q[0] : '0);
            chk("fifo_count",  bus.fifo_count,     m_q.size());
            chk("fresh_mask",  bus.fresh_mask,     m_fresh);
        end
    end

    // Consumer-side order check for the backpressure run
    always @(negedge clk) begin
        if (rx_on && bus.rtl_valid && bus.rtl_ready) begin
            chk("rx_order", bus.rtl_data, pat(16'h5000, rx_cnt));
            rx_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int idx, input logic [W-1:0] d, output logic [1:0] resp);
        bus.ps_wr_en   = 1'b1;
        bus.ps_wr_idx  = IDXW'(idx);
        bus.ps_wr_data = d;
        tick();
        bus.ps_wr_en   = 1'b0;
        resp = bus.ps_wr_resp;
    endtask

    task automatic rd(input int idx, output logic [W-1:0] d);
        bus.ps_rd_en  = 1'b1;
        bus.ps_rd_idx = IDXW'(idx);
        tick();
        bus.ps_rd_en  = 1'b0;
        d = bus.ps_rd_data;
    endtask

    task automatic load_all(input int base, input int k);
        logic [1:0] r;
        logic [BIG-1:0] v;
        v = pat(base, k);
        for (int i = 0; i < S; i++) wr(i, v[i*W +: W], r);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] r;
        logic [W-1:0] d;
        int tries;
        bus.ps_wr_en = 1'b0; bus.ps_wr_idx = '0; bus.ps_wr_data = '0;
        bus.ps_rd_en = 1'b0; bus.ps_rd_idx = '0; bus.rtl_ready = 1'b0;
        rst_n = 1'b0;
        tick(); tick();
        chk_on = 1'b1;
        chk("reset_count", bus.fifo_count, 0);
        chk("reset_valid", bus.rtl_valid, 0);
        rst_n = 1'b1;

        // Full assembly and commit
        for (int i = 0; i < S; i++) begin
            wr(i, W'(16'h1000 + i), r);
            chk("chunk_okay", r, 2'b00);
        end
        wr(S, '0, r);
        chk("commit_okay", r, 2'b00);
        chk("commit_valid_n1", bus.rtl_valid, 1);
        chk("commit_lo", bus.rtl_data[15:0], 16'h1000);
        chk("commit_hi", bus.rtl_data[255:240], 16'h100F);
        chk("commit_fresh", bus.fresh_mask, 0);
        bus.rtl_ready = 1'b1; tick(); bus.rtl_ready = 1'b0;
        chk("pop_empty", bus.rtl_valid, 0);

        // Incomplete commit
        for (int i = 0; i < S-1; i++) wr(i, W'(16'h2000 + i), r);
        wr(S, '0, r);
`ifdef BIGREG_PARTIAL_COMMIT_EN
        chk("partial_okay", r, 2'b00);
        chk("partial_fresh", bus.fresh_mask, 0);
        chk("partial_hi", bus.rtl_data[255:240], 16'h100F);
        chk("partial_lo", bus.rtl_data[15:0], 16'h2000);
        bus.rtl_ready = 1'b1; tick(); bus.rtl_ready = 1'b0;
`else
        chk("partial_slverr", r, 2'b10);
        chk("partial_fresh", bus.fresh_mask, 16'h7FFF);
        chk("partial_nopush", bus.fifo_count, 0);
`endif
        rd(15, d);
        chk("stale_chunk15", d, 16'h100F);

        // Full FIFO, then commit with same-cycle pop
        for (int k = 0; k < 5; k++) begin
            load_all(16'h3000, k);
            wr(S, '0, r);
            chk("fill_resp", r, (k < D) ? 2'b00 : 2'b10);
        end
        chk("full_count", bus.fifo_count, 4);
        bus.rtl_ready = 1'b1;
        wr(S, '0, r);
        bus.rtl_ready = 1'b0;
        chk("pushpop_okay", r, 2'b00);
        chk("pushpop_count", bus.fifo_count, 4);
        chk("pushpop_head", bus.rtl_data[15:0], 16'h3010);
        bus.rtl_ready = 1'b1;
        for (int i = 0; i < D; i++) tick();
        bus.rtl_ready = 1'b0;
        chk("drained", bus.fifo_count, 0);

        // Reset mid-sequence
        load_all(16'h4000, 0);
        wr(S, '0, r);
        for (int i = 0; i < 8; i++) wr(i, W'(16'h4100 + i), r);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("rst_fresh", bus.fresh_mask, 0);
        chk("rst_valid", bus.rtl_valid, 0);
        chk("rst_count", bus.fifo_count, 0);
        rd(3, d);
        chk("rst_rd3", d, 0);

        // Decode errors and count readback
        wr(0, 16'hABCD, r);
        wr(17, 16'h5555, r);
        chk("decerr", r, 2'b11);
        chk("decerr_fresh", bus.fresh_mask, 16'h0001);
        rd(0, d);
        chk("decerr_nochange", d, 16'hABCD);
        rd(17, d);
        chk("rd_bad", d, 16'hFFFE);
        for (int k = 0; k < 2; k++) begin
            load_all(16'h4800, k);
            wr(S, '0, r);
        end
        rd(16, d);
        chk("rd_count", d, 2);
        bus.rtl_ready = 1'b1; tick(); tick(); bus.rtl_ready = 1'b0;

        // 100 commits under random backpressure
        rx_on = 1'b1;
        fork
            begin
                for (int k = 0; k < 100; k++) begin
                    load_all(16'h5000, k);
                    tries = 0;
                    do begin
                        wr(S, '0, r);
                        tries++;
                    end while (r != 2'b00 && tries < 100);
                    if (r != 2'b00) chk("commit_retry", r, 2'b00);
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    bus.rtl_ready = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        bus.rtl_ready = 1'b1;
        for (int i = 0; i < 50 && rx_cnt < 100; i++) tick();
        chk("rx_count", rx_cnt, 100);
        bus.rtl_ready = 1'b0;
        rx_on = 1'b0;
        tick();
        chk_on = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
`default_nettype wire
